// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
//   Hazard and forwarding control for the 5-stage RV32I pipeline
//   (IF/ID/EX/MEM/WB). Produces per-register stall/flush controls, EX-stage
//   operand forward selects, a multi-cycle MEM-access wait, and three
//   saturating performance counters.
//
//   Parameters
//     FWD_EN    : 0 = stall on any RAW hazard, 1 = forward from MEM/WB and
//                 stall only on load-use
//     RF_BYPASS : 1 = regfile is write-before-read, WB match needs no stall
//     MEM_LAT   : cycles a load/store occupies MEM (>=1)
//     CNT_W     : performance counter width
//
//   Ports
//     i_clk, i_reset            clock, asynchronous active-high reset
//     i_ID_rs{1,2}_addr         ID-stage source registers
//     i_EX_rs{1,2}_addr         EX-stage source registers (forwarding)
//     i_EX_rd_addr/_wren        EX destination and write enable
//     i_EX_is_load, i_EX_pc_sel EX holds a load / EX redirects the PC
//     i_MEM_rd_addr/_wren       MEM destination and write enable
//     i_MEM_mem_req             valid load/store in MEM
//     i_WB_rd_addr/_wren        WB destination and write enable
//     i_WB_insn_vld             valid instruction in WB
//     i_cnt_clr                 synchronous clear of all counters
//     o_*_stall / o_*_flush     hold / bubble controls per pipeline register
//     o_fwd_{a,b}_sel           00 pipeline, 01 MEM alu_data, 10 WB rd_data
//     o_mem_busy                MEM wait is holding the pipeline
//     o_stall_cnt               cycles with o_pc_stall=1
//     o_flush_cnt               redirect events
//     o_retire_cnt              cycles with i_WB_insn_vld=1
// ---------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int MEM_LAT   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_ID_rs1_addr,
  input  logic [4:0]       i_ID_rs2_addr,
  input  logic [4:0]       i_EX_rs1_addr,
  input  logic [4:0]       i_EX_rs2_addr,
  input  logic [4:0]       i_EX_rd_addr,
  input  logic             i_EX_rd_wren,
  input  logic             i_EX_is_load,
  input  logic             i_EX_pc_sel,
  input  logic [4:0]       i_MEM_rd_addr,
  input  logic             i_MEM_rd_wren,
  input  logic             i_MEM_mem_req,
  input  logic [4:0]       i_WB_rd_addr,
  input  logic             i_WB_rd_wren,
  input  logic             i_WB_insn_vld,
  input  logic             i_cnt_clr,
  output logic             o_pc_stall,
  output logic             o_IF_ID_stall,
  output logic             o_ID_EX_stall,
  output logic             o_EX_MEM_stall,
  output logic             o_MEM_WB_stall,
  output logic             o_IF_ID_flush,
  output logic             o_ID_EX_flush,
  output logic             o_EX_MEM_flush,
  output logic             o_MEM_WB_flush,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_mem_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int MC_W = $clog2(MEM_LAT) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MC_W-1:0] r_mcnt;
  logic [MC_W-1:0] w_mcnt_nxt;
  logic            w_mem_wait;
  logic            w_redirect;
  logic            w_id_ex;
  logic            w_id_mem;
  logic            w_id_wb;
  logic            w_hazard;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  // A source depends on a stage when it is not x0, names that stage's rd,
  // and that stage actually writes rd.
  function automatic logic f_match(input logic [4:0] src,
                                   input logic [4:0] rd,
                                   input logic       wren);
    return wren && (src != 5'd0) && (src == rd);
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // MEM wait FSM: the first cycle of a memory op is seen in IDLE and already
  // stalls; WAIT then stalls while more than one cycle remains. The last
  // cycle (cnt==1) is the release cycle in which the pipeline moves again.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcnt  <= w_mcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    w_mem_wait  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_MEM_mem_req && (MEM_LAT > 1)) begin
          w_mem_wait  = 1'b1;
          w_mcnt_nxt  = MC_W'(MEM_LAT - 1);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_mcnt > MC_W'(1)) begin
          w_mem_wait = 1'b1;
          w_mcnt_nxt = r_mcnt - MC_W'(1);
        end else begin
          w_mcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mcnt_nxt  = '0;
      end
    endcase
  end

  // Busy covers the WAIT cycles that still hold the pipeline, not the
  // release cycle.
  assign o_mem_busy = (r_state == S_WAIT) && (r_mcnt > MC_W'(1));

  // ID-stage dependence on each older stage
  assign w_id_ex  = f_match(i_ID_rs1_addr, i_EX_rd_addr, i_EX_rd_wren) |
                    f_match(i_ID_rs2_addr, i_EX_rd_addr, i_EX_rd_wren);
  assign w_id_mem = f_match(i_ID_rs1_addr, i_MEM_rd_addr, i_MEM_rd_wren) |
                    f_match(i_ID_rs2_addr, i_MEM_rd_addr, i_MEM_rd_wren);
  assign w_id_wb  = f_match(i_ID_rs1_addr, i_WB_rd_addr, i_WB_rd_wren) |
                    f_match(i_ID_rs2_addr, i_WB_rd_addr, i_WB_rd_wren);

  // With forwarding only a load in EX cannot be bypassed in time; without
  // it every in-flight producer must reach the regfile first.
  assign w_hazard = (FWD_EN != 0) ? (i_EX_is_load & w_id_ex)
                                  : (w_id_ex | w_id_mem |
                                     ((RF_BYPASS == 0) & w_id_wb));

  // Stall/flush priority: reset > MEM wait > redirect > data hazard.
  // During MEM wait WB keeps retiring and gets bubbles behind it; a held
  // redirect therefore only takes effect in the release cycle.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_IF_ID_stall  = 1'b0;
    o_ID_EX_stall  = 1'b0;
    o_EX_MEM_stall = 1'b0;
    o_MEM_WB_stall = 1'b0;
    o_IF_ID_flush  = 1'b0;
    o_ID_EX_flush  = 1'b0;
    o_EX_MEM_flush = 1'b0;
    o_MEM_WB_flush = 1'b0;
    w_redirect     = 1'b0;
    if (i_reset) begin
      w_redirect = 1'b0;
    end else if (w_mem_wait) begin
      o_pc_stall     = 1'b1;
      o_IF_ID_stall  = 1'b1;
      o_ID_EX_stall  = 1'b1;
      o_EX_MEM_stall = 1'b1;
      o_MEM_WB_flush = 1'b1;
    end else if (i_EX_pc_sel) begin
      o_IF_ID_flush = 1'b1;
      o_ID_EX_flush = 1'b1;
      w_redirect    = 1'b1;
    end else if (w_hazard) begin
      o_pc_stall    = 1'b1;
      o_IF_ID_stall = 1'b1;
      o_ID_EX_flush = 1'b1;
    end
  end

  // Forward selects are a pure datapath mux choice for whatever sits in EX;
  // they stay live under stalls so a held instruction sees current data.
  always_comb begin
    o_fwd_a_sel = 2'b00;
    o_fwd_b_sel = 2'b00;
    if (!i_reset && (FWD_EN != 0)) begin
      if (f_match(i_EX_rs1_addr, i_MEM_rd_addr, i_MEM_rd_wren))
        o_fwd_a_sel = 2'b01;
      else if (f_match(i_EX_rs1_addr, i_WB_rd_addr, i_WB_rd_wren))
        o_fwd_a_sel = 2'b10;
      if (f_match(i_EX_rs2_addr, i_MEM_rd_addr, i_MEM_rd_wren))
        o_fwd_b_sel = 2'b01;
      else if (f_match(i_EX_rs2_addr, i_WB_rd_addr, i_WB_rd_wren))
        o_fwd_b_sel = 2'b10;
    end
  end

  // Performance counters: clear wins over increment, all saturate.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (o_pc_stall)    r_stall_cnt  <= f_sat_inc(r_stall_cnt);
      if (w_redirect)    r_flush_cnt  <= f_sat_inc(r_flush_cnt);
      if (i_WB_insn_vld) r_retire_cnt <= f_sat_inc(r_retire_cnt);
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_retire_cnt = r_retire_cnt;

endmodule
